// File: rtl/lsu_mem_access_pkg.sv
// lsu_mem_access_pkg: shared access-size codes, LSU state encoding and decoder opcodes
package lsu_mem_access_pkg;
    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;
    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_STORE = 7'b0100011;
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;
endpackage

// File: rtl/lsu_mem_access_align.sv
// lsu_mem_access_align: byte enables, store lane replication, load extension and misalign detection
module lsu_mem_access_align
    import lsu_mem_access_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [2:0]      funct3,
    input  logic [1:0]      off,
    input  logic [XLEN-1:0] wdata,
    input  logic [XLEN-1:0] rdata,
    output logic [3:0]      be,
    output logic [XLEN-1:0] wlanes,
    output logic [XLEN-1:0] rext,
    output logic            mis
);
    logic       is_b, is_h, uns;
    logic [7:0] b;
    logic [15:0] h;
    // Unsupported size codes fall through to word behaviour
    always_comb begin
        is_b   = funct3 == F3_B || funct3 == F3_BU;
        is_h   = funct3 == F3_H || funct3 == F3_HU;
        uns    = funct3 == F3_BU || funct3 == F3_HU;
        b      = rdata[{off, 3'b000} +: 8];
        h      = rdata[{off[1], 4'b0000} +: 16];
        be     = is_b ? 4'b0001 << off : is_h ? 4'b0011 << off : 4'b1111;
        wlanes = is_b ? {4{wdata[7:0]}} : is_h ? {2{wdata[15:0]}} : wdata;
        rext   = is_b ? {{(XLEN-8){b[7] & ~uns}}, b} :
                 is_h ? {{(XLEN-16){h[15] & ~uns}}, h} : rdata;
        mis    = is_b ? 1'b0 : is_h ? off[0] : off != 2'b00;
    end
endmodule

// File: rtl/lsu_mem_access.sv
// lsu_mem_access: single-outstanding load/store unit with pipeline stall and bus timeout
module lsu_mem_access
    import lsu_mem_access_pkg::*;
#(
    parameter int XLEN    = 32,
    parameter int TIMEOUT = 255
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            mem_read_i,
    input  logic            mem_write_i,
    input  logic [2:0]      funct3_i,
    input  logic [XLEN-1:0] addr_i,
    input  logic [XLEN-1:0] wdata_i,
    output logic            stall_o,
    output logic [XLEN-1:0] rdata_o,
    output logic            done_o,
    output logic            misalign_o,
    output logic            bus_err_o,
    output logic            mem_req_o,
    output logic            mem_we_o,
    output logic [XLEN-1:0] mem_addr_o,
    output logic [3:0]      mem_be_o,
    output logic [XLEN-1:0] mem_wdata_o,
    input  logic [XLEN-1:0] mem_rdata_i,
    input  logic            mem_ack_i
);
    localparam int CW = TIMEOUT > 1 ? $clog2(TIMEOUT) : 1;
    state_t          state;
    logic [CW-1:0]   cnt;
    logic [2:0]      f3_q, f3_sel;
    logic [1:0]      off_q, off_sel;
    logic            req, mis, tmo;
    logic [3:0]      be;
    logic [XLEN-1:0] wl, rx;
    // In IDLE the aligner sees the incoming request; afterwards the captured one
    always_comb begin
        req       = mem_read_i | mem_write_i;
        f3_sel    = state == IDLE ? funct3_i : f3_q;
        off_sel   = state == IDLE ? addr_i[1:0] : off_q;
        tmo       = TIMEOUT > 0 && cnt == CW'(TIMEOUT - 1);
        stall_o   = state == BUSY || (state == IDLE && req && !mis);
        mem_req_o = state == BUSY;
    end
    lsu_mem_access_align #(.XLEN(XLEN)) u_align (
        .funct3(f3_sel),
        .off   (off_sel),
        .wdata (wdata_i),
        .rdata (mem_rdata_i),
        .be    (be),
        .wlanes(wl),
        .rext  (rx),
        .mis   (mis)
    );
    // Access FSM, timeout counter and registered bus/result outputs
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state       <= IDLE;
            cnt         <= '0;
            f3_q        <= '0;
            off_q       <= '0;
            mem_we_o    <= 1'b0;
            mem_addr_o  <= '0;
            mem_be_o    <= '0;
            mem_wdata_o <= '0;
            rdata_o     <= '0;
            done_o      <= 1'b0;
            misalign_o  <= 1'b0;
            bus_err_o   <= 1'b0;
        end else begin
            done_o     <= 1'b0;
            misalign_o <= 1'b0;
            bus_err_o  <= 1'b0;
            case (state)
                IDLE: begin
                    if (req && mis) begin
                        misalign_o <= 1'b1;
                    end else if (req) begin
                        state       <= BUSY;
                        cnt         <= '0;
                        mem_we_o    <= mem_write_i;
                        mem_addr_o  <= {addr_i[XLEN-1:2], 2'b00};
                        mem_be_o    <= be;
                        mem_wdata_o <= wl;
                        f3_q        <= funct3_i;
                        off_q       <= addr_i[1:0];
                    end
                end
                BUSY: begin
                    if (mem_ack_i) begin
                        state  <= DONE;
                        done_o <= 1'b1;
                        if (!mem_we_o) rdata_o <= rx;
                    end else if (tmo) begin
                        state     <= DONE;
                        done_o    <= 1'b1;
                        bus_err_o <= 1'b1;
                        rdata_o   <= '0;
                    end else begin
                        cnt <= cnt + CW'(cnt != '1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_lsu_mem_access.sv
// tb_lsu_mem_access: directed self-checking bench for the load/store unit
module tb_lsu_mem_access;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        rd = 1'b0, wr = 1'b0, rd_t = 1'b0, wr_t = 1'b0;
    logic [2:0]  f3 = 3'b010;
    logic [31:0] addr = '0, wdata = '0, mrdata = '0;
    logic        ack = 1'b0, ack_t = 1'b0;
    logic        stall, done, mis, berr, req, we;
    logic [31:0] rdata, maddr, mwdata;
    logic [3:0]  be;
    logic        stall_t, done_t, mis_t, berr_t, req_t, we_t;
    logic [31:0] rdata_t, maddr_t, mwdata_t;
    logic [3:0]  be_t;
    int checks = 0, errors = 0;
    int          r_stall, r_req;
    logic [3:0]  r_be;
    logic [31:0] r_addr, r_wdata, r_rdata;
    logic        r_we, r_done, r_err, r_stable;

    always #5 clk = ~clk;

    lsu_mem_access dut (
        .clk_i(clk), .rst_i(rst), .mem_read_i(rd), .mem_write_i(wr), .funct3_i(f3),
        .addr_i(addr), .wdata_i(wdata), .stall_o(stall), .rdata_o(rdata), .done_o(done),
        .misalign_o(mis), .bus_err_o(berr), .mem_req_o(req), .mem_we_o(we),
        .mem_addr_o(maddr), .mem_be_o(be), .mem_wdata_o(mwdata),
        .mem_rdata_i(mrdata), .mem_ack_i(ack)
    );

    lsu_mem_access #(.TIMEOUT(4)) dut_t (
        .clk_i(clk), .rst_i(rst), .mem_read_i(rd_t), .mem_write_i(wr_t), .funct3_i(f3),
        .addr_i(addr), .wdata_i(wdata), .stall_o(stall_t), .rdata_o(rdata_t), .done_o(done_t),
        .misalign_o(mis_t), .bus_err_o(berr_t), .mem_req_o(req_t), .mem_we_o(we_t),
        .mem_addr_o(maddr_t), .mem_be_o(be_t), .mem_wdata_o(mwdata_t),
        .mem_rdata_i(mrdata), .mem_ack_i(ack_t)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic run_access(input logic r, input logic w, input logic [2:0] f, input logic [31:0] a,
                              input logic [31:0] wd, input logic [31:0] md, input int dly);
        rd = r; wr = w; f3 = f; addr = a; wdata = wd; mrdata = md;
        r_stall = 0; r_req = 0; r_done = 0; r_err = 0; r_stable = 1;
        r_be = '0; r_addr = '0; r_wdata = '0; r_we = 0; r_rdata = '0;
        #1;
        for (int c = 0; c < 300; c++) begin
            if (stall) r_stall++;
            if (req) begin
                r_req++;
                if (r_req == 1) begin
                    r_be = be; r_addr = maddr; r_wdata = mwdata; r_we = we;
                end else if (be !== r_be || maddr !== r_addr || mwdata !== r_wdata || we !== r_we) begin
                    r_stable = 0;
                end
                ack = (r_req == dly);
            end else begin
                ack = 1'b0;
            end
            if (done) begin
                r_done = 1; r_err = berr; r_rdata = rdata;
                break;
            end
            step();
            rd = 1'b0; wr = 1'b0;
        end
        ack = 1'b0;
        step();
    endtask

    task automatic test_reset();
        checks++;
        if ({stall, done, mis, berr, req, we, be, rdata, maddr, mwdata} !== '0) begin
            errors++;
            $display("FAIL reset_outputs got stall=%b done=%b req=%b be=%b rdata=%h want all zero",
                     stall, done, req, be, rdata);
        end
        checks++;
        if ({stall_t, done_t, req_t, berr_t} !== 4'b0) begin
            errors++;
            $display("FAIL reset_outputs_t got %b want 0000", {stall_t, done_t, req_t, berr_t});
        end
    endtask

    task automatic test_lw();
        run_access(1'b1, 1'b0, 3'b010, 32'h100, 32'h0, 32'hDEADBEEF, 1);
        checks++;
        if (r_be !== 4'b1111 || r_addr !== 32'h100 || r_we !== 1'b0) begin
            errors++;
            $display("FAIL lw_bus got be=%b addr=%h we=%b want 1111 00000100 0", r_be, r_addr, r_we);
        end
        checks++;
        if (r_stall !== 2) begin
            errors++;
            $display("FAIL lw_stall got %0d want 2", r_stall);
        end
        checks++;
        if (r_done !== 1'b1 || r_rdata !== 32'hDEADBEEF || r_err !== 1'b0) begin
            errors++;
            $display("FAIL lw_data got done=%b rdata=%h err=%b want 1 deadbeef 0", r_done, r_rdata, r_err);
        end
        checks++;
        if (done !== 1'b0 || stall !== 1'b0) begin
            errors++;
            $display("FAIL lw_done_pulse got done=%b stall=%b want 0 0", done, stall);
        end
    endtask

    task automatic test_lb_lbu();
        run_access(1'b1, 1'b0, 3'b000, 32'h103, 32'h0, 32'h80FFFFFF, 1);
        checks++;
        if (r_be !== 4'b1000 || r_addr !== 32'h100 || r_rdata !== 32'hFFFFFF80) begin
            errors++;
            $display("FAIL lb got be=%b addr=%h rdata=%h want 1000 00000100 ffffff80", r_be, r_addr, r_rdata);
        end
        run_access(1'b1, 1'b0, 3'b100, 32'h103, 32'h0, 32'h80FFFFFF, 1);
        checks++;
        if (r_be !== 4'b1000 || r_rdata !== 32'h00000080) begin
            errors++;
            $display("FAIL lbu got be=%b rdata=%h want 1000 00000080", r_be, r_rdata);
        end
        run_access(1'b1, 1'b0, 3'b001, 32'h102, 32'h0, 32'hF00D1234, 2);
        checks++;
        if (r_be !== 4'b1100 || r_rdata !== 32'hFFFFF00D) begin
            errors++;
            $display("FAIL lh got be=%b rdata=%h want 1100 fffff00d", r_be, r_rdata);
        end
        run_access(1'b1, 1'b0, 3'b101, 32'h102, 32'h0, 32'hF00D1234, 1);
        checks++;
        if (r_rdata !== 32'h0000F00D) begin
            errors++;
            $display("FAIL lhu got rdata=%h want 0000f00d", r_rdata);
        end
        run_access(1'b1, 1'b0, 3'b000, 32'h101, 32'h0, 32'h00007F00, 1);
        checks++;
        if (r_be !== 4'b0010 || r_rdata !== 32'h0000007F) begin
            errors++;
            $display("FAIL lb_pos got be=%b rdata=%h want 0010 0000007f", r_be, r_rdata);
        end
    endtask

    task automatic test_stores();
        run_access(1'b0, 1'b1, 3'b001, 32'h102, 32'h1234ABCD, 32'h0, 5);
        checks++;
        if (r_we !== 1'b1 || r_be !== 4'b1100 || r_wdata !== 32'hABCDABCD || r_addr !== 32'h100) begin
            errors++;
            $display("FAIL sh_bus got we=%b be=%b wdata=%h addr=%h want 1 1100 abcdabcd 00000100",
                     r_we, r_be, r_wdata, r_addr);
        end
        checks++;
        if (r_stall !== 6 || r_req !== 5 || r_stable !== 1'b1) begin
            errors++;
            $display("FAIL sh_timing got stall=%0d req=%0d stable=%b want 6 5 1", r_stall, r_req, r_stable);
        end
        checks++;
        if (r_rdata !== 32'h0000F00D - 32'hF00D + 32'h7F) begin
            errors++;
            $display("FAIL store_keeps_rdata got %h want 0000007f", r_rdata);
        end
        run_access(1'b1, 1'b1, 3'b000, 32'h101, 32'h00000055, 32'hFFFFFFFF, 1);
        checks++;
        if (r_we !== 1'b1 || r_be !== 4'b0010 || r_wdata !== 32'h55555555) begin
            errors++;
            $display("FAIL sb_both got we=%b be=%b wdata=%h want 1 0010 55555555", r_we, r_be, r_wdata);
        end
        run_access(1'b0, 1'b1, 3'b111, 32'h208, 32'hCAFEF00D, 32'h0, 1);
        checks++;
        if (r_be !== 4'b1111 || r_wdata !== 32'hCAFEF00D || r_addr !== 32'h208) begin
            errors++;
            $display("FAIL sw_bad_f3 got be=%b wdata=%h addr=%h want 1111 cafef00d 00000208",
                     r_be, r_wdata, r_addr);
        end
    endtask

    task automatic test_misalign();
        rd = 1'b1; f3 = 3'b010; addr = 32'h101;
        #1;
        checks++;
        if (stall !== 1'b0) begin
            errors++;
            $display("FAIL misalign_stall got %b want 0", stall);
        end
        step();
        rd = 1'b0;
        checks++;
        if (mis !== 1'b1 || req !== 1'b0) begin
            errors++;
            $display("FAIL misalign_pulse got mis=%b req=%b want 1 0", mis, req);
        end
        step();
        checks++;
        if (mis !== 1'b0 || req !== 1'b0 || done !== 1'b0) begin
            errors++;
            $display("FAIL misalign_once got mis=%b req=%b done=%b want 0 0 0", mis, req, done);
        end
        wr = 1'b1; f3 = 3'b001; addr = 32'h103;
        #1;
        step();
        wr = 1'b0;
        checks++;
        if (mis !== 1'b1 || req !== 1'b0) begin
            errors++;
            $display("FAIL misalign_sh got mis=%b req=%b want 1 0", mis, req);
        end
        step();
    endtask

    task automatic test_timeout();
        int n, seen;
        logic both, zero;
        n = 0; seen = 0; both = 0; zero = 0;
        wr_t = 1'b1; f3 = 3'b010; addr = 32'h200; wdata = 32'h11223344;
        #1;
        for (int c = 0; c < 50; c++) begin
            if (req_t) n++;
            if (done_t || berr_t) begin
                seen = 1; both = done_t & berr_t; zero = rdata_t == 32'h0;
                break;
            end
            step();
            wr_t = 1'b0;
        end
        checks++;
        if (seen !== 1 || both !== 1'b1 || zero !== 1'b1) begin
            errors++;
            $display("FAIL timeout_err got seen=%0d both=%b rzero=%b want 1 1 1", seen, both, zero);
        end
        checks++;
        if (n !== 4) begin
            errors++;
            $display("FAIL timeout_req_cycles got %0d want 4", n);
        end
        step();
        checks++;
        if (req_t !== 1'b0 || done_t !== 1'b0 || berr_t !== 1'b0 || stall_t !== 1'b0) begin
            errors++;
            $display("FAIL timeout_idle got req=%b done=%b err=%b stall=%b want 0 0 0 0",
                     req_t, done_t, berr_t, stall_t);
        end
        rd_t = 1'b1;
        #1;
        checks++;
        if (stall_t !== 1'b1) begin
            errors++;
            $display("FAIL timeout_back_idle got stall=%b want 1", stall_t);
        end
        rd_t = 1'b0;
        #1;
    endtask

    task automatic test_reset_busy();
        logic spur;
        spur = 0;
        rd = 1'b1; f3 = 3'b010; addr = 32'h300;
        step();
        rd = 1'b0;
        checks++;
        if (req !== 1'b1) begin
            errors++;
            $display("FAIL rst_busy_enter got req=%b want 1", req);
        end
        rst = 1'b1;
        step();
        checks++;
        if (req !== 1'b0 || done !== 1'b0) begin
            errors++;
            $display("FAIL rst_busy_drop got req=%b done=%b want 0 0", req, done);
        end
        rst = 1'b0;
        for (int c = 0; c < 3; c++) begin
            if (done || req) spur = 1;
            step();
        end
        checks++;
        if (spur !== 1'b0) begin
            errors++;
            $display("FAIL rst_busy_no_done got activity=%b want 0", spur);
        end
        run_access(1'b1, 1'b0, 3'b010, 32'h104, 32'h0, 32'h0BADF00D, 1);
        checks++;
        if (r_done !== 1'b1 || r_rdata !== 32'h0BADF00D || r_addr !== 32'h104 || r_stall !== 2) begin
            errors++;
            $display("FAIL rst_then_lw got done=%b rdata=%h addr=%h stall=%0d want 1 0badf00d 00000104 2",
                     r_done, r_rdata, r_addr, r_stall);
        end
    endtask

    initial begin
        rst = 1'b1;
        step();
        step();
        test_reset();
        rst = 1'b0;
        step();
        test_lw();
        test_lb_lbu();
        test_stores();
        test_misalign();
        test_timeout();
        test_reset_busy();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/lsu_mem_access.md
Name: lsu_mem_access

Overview:
- Load/store unit that consumes the decoder's mem_read/mem_write/mem_to_reg controls and the ALU address.
- Drives a single-outstanding req/ack data-memory bus and stalls the core until the access completes.
- Returns sign/zero-extended load data to writeback.
- Sits between the EX stage and data memory; it is the responder end of the decoder's memory-control outputs.

Parameters:
- XLEN, 32, data/address width (only 32 supported).
- TIMEOUT, 255, max cycles waiting for mem_ack_i before a bus error; 0 disables the timeout.

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  synchronous active-high reset.
- mem_read_i  in  1  load requested (decoder mem_read).
- mem_write_i  in  1  store requested (decoder mem_write).
- funct3_i  in  3  access size/sign: 000 B, 001 H, 010 W, 100 BU, 101 HU.
- addr_i  in  XLEN  byte address from the ALU.
- wdata_i  in  XLEN  store data (rs2).
- stall_o  out  1  hold the pipeline.
- rdata_o  out  XLEN  extended load result.
- done_o  out  1  one-cycle completion pulse.
- misalign_o  out  1  one-cycle misaligned-access pulse.
- bus_err_o  out  1  one-cycle timeout pulse.
- mem_req_o  out  1  bus request.
- mem_we_o  out  1  bus write enable.
- mem_addr_o  out  XLEN  word-aligned address, with bits [1:0] = 0.
- mem_be_o  out  4  byte enables.
- mem_wdata_o  out  XLEN  lane-replicated store data.
- mem_rdata_i  in  XLEN  read data, valid with ack.
- mem_ack_i  in  1  access complete.

Behaviour:
- Reset: state=IDLE; all outputs 0; timeout counter 0. Reset mid-access abandons it: mem_req_o drops the next cycle and no done_o is produced.
- States: IDLE, BUSY, DONE.
- IDLE, with (mem_read_i|mem_write_i) and aligned:
  - stall_o=1 combinationally in the same cycle.
  - Next edge: register the we bit, addr, be, wdata and funct3; go to BUSY.
- IDLE, misaligned (H with addr[0]=1, or W with addr[1:0]!=0):
  - No bus access; stall_o stays 0.
  - misalign_o=1 next cycle for exactly one cycle.
- Both mem_read_i and mem_write_i high: treat as a store.
- An unsupported funct3 (011, 110, 111) is treated as W.
- BUSY:
  - mem_req_o=1 and stall_o=1.
  - Bus outputs remain stable until ack.
  - Counter increments each cycle.
- BUSY, mem_ack_i=1: capture the extended mem_rdata_i into rdata_o (loads only); go to DONE.
- BUSY, counter==TIMEOUT-1 without ack (TIMEOUT>0):
  - Go to DONE with bus_err_o set.
  - rdata_o=0.
  - mem_req_o drops.
- DONE:
  - stall_o=0 and done_o=1 for one cycle; the core advances at this edge.
  - Next edge: go to IDLE.
  - Request inputs are ignored in DONE.
- Minimum latency: 3 cycles (request, 1-cycle ack, done). The stall lasts (ack wait + 1) cycles.
- Byte enables:
  - B: 0001 << addr[1:0].
  - H: 0011 << addr[1:0].
  - W: 1111.
- Store data lanes: B replicates wdata[7:0] into all four bytes; H replicates wdata[15:0] into both halves.
- Load extraction:
  - Select the byte/half lane by addr[1:0].
  - B and H sign-extend; BU and HU zero-extend.
- rdata_o holds its value until the next completed load.
- mem_ack_i outside BUSY is ignored.
- The counter resets on entry to BUSY and does not wrap.

Decomposition:
- Shared package holds:
  - funct3 size constants (F3_B, F3_H, F3_W, F3_BU, F3_HU).
  - State encoding (IDLE=2'd0, BUSY=2'd1, DONE=2'd2).
  - Opcode defines already used by the decoder.
- One natural sub-module, lsu_align:
  - Combinational; maps funct3, addr[1:0], wdata and rdata to be, store lanes, extended load data and the misalign flag.
  - The top level holds the FSM and the counter.

Test Plan:
- LW addr=0x100, ack one cycle after request, mem_rdata=0xDEADBEEF:
  - mem_be_o=1111 and mem_addr_o=0x100.
  - stall_o high for 2 cycles.
  - done_o pulses and rdata_o=0xDEADBEEF.
- LB addr=0x103 with rdata=0x80FFFFFF: be=1000, rdata_o=0xFFFFFF80. The same access as LBU gives rdata_o=0x00000080.
- SH addr=0x102, wdata=0x1234ABCD: mem_we_o=1, be=1100, mem_wdata_o=0xABCDABCD, ack delayed 5 cycles, stall_o high for 6 cycles.
- LW addr=0x101: no mem_req_o, misalign_o pulses once, stall_o stays 0.
- TIMEOUT=4, SW never acked:
  - mem_req_o is high for exactly 4 cycles.
  - bus_err_o and done_o pulse together.
  - FSM returns to IDLE.
- rst_i asserted during BUSY: mem_req_o=0 next cycle, no done_o, and a following LW completes normally.
